// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - seven-segment constants shared by the scan controller
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low a..g patterns, listed from F (index 15) down to 0 (index 0)
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - hex nibble to active-low a..g segment pattern
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     blank_en,
    input  logic                  lz_en,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q, frame_done_d;

    logic                tick;
    logic                frame_wrap;
    logic                digit_off;
    logic                all_zero;
    logic [DIGITS-1:0]   lz_suppress;
    logic [3:0]          cur_nib;
    logic [6:0]          dec_seg;

    // Walk from the most significant digit down; digit 0 always stays lit
    always_comb begin
        all_zero    = 1'b1;
        lz_suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero       = all_zero & (shadow_data_q[4*i +: 4] == 4'h0);
            lz_suppress[i] = lz_en & all_zero & (i != 0);
        end
    end

    assign cur_nib = shadow_data_q[{idx_q, 2'b00} +: 4];

    seg_decode u_seg_decode (
        .nibble (cur_nib),
        .seg_n  (dec_seg)
    );

    always_comb begin
        tick       = (div_cnt_q == DW'(SCAN_DIV - 1));
        frame_wrap = tick && (idx_q == IW'(DIGITS - 1));

        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_wrap) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        shadow_data_d  = shadow_data_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        if (load) begin
            shadow_data_d  = data;
            shadow_dp_d    = dp_en;
            shadow_blank_d = blank_en;
        end

        // A dark digit still owns its slot so duty cycle is unchanged
        digit_off    = shadow_blank_q[idx_q] | lz_suppress[idx_q]
                     | (blink_mask[idx_q] & blink_phase_q);
        frame_done_d = frame_wrap;
        if (digit_off) begin
            an_d  = '1;
            seg_d = SEG_OFF;
        end else begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = {dec_seg, ~shadow_dp_q[idx_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q      <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            an_q           <= '1;
            seg_q          <= SEG_OFF;
            frame_done_q   <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (4 digits, 4 clk slots)
module tb_seg_scan_ctrl;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [15:0] data       = '0;
    logic        load       = 1'b0;
    logic [3:0]  dp_en      = '0;
    logic [3:0]  blank_en   = '0;
    logic        lz_en      = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   cyc     = 0;
    int   rst_run = 0;
    int   fr      = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   done    = 1'b0;
    logic fd_exp;

    seg_scan_ctrl #(
        .DIGITS       (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .dp_en      (dp_en),
        .blank_en   (blank_en),
        .lz_en      (lz_en),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // cyc = number of non-reset edges since the last reset edge
    always @(posedge clk) begin
        if (rst) begin
            cyc     <= 0;
            rst_run <= rst_run + 1;
        end else begin
            cyc     <= cyc + 1;
            rst_run <= 0;
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            if (rst_run == 1 || (rst_run == 0 && cyc % 4 == 2)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL slot_underflow cyc=%0d: an=%b seg=%h, expected no output sample", cyc, an, seg);
                end else begin
                    mon_x = exp_q.pop_front();
                    if (an !== mon_x.an || seg !== mon_x.seg) begin
                        n_err++;
                        $display("FAIL slot id=%0d: an=%b seg=%h, expected an=%b seg=%h",
                                 mon_x.id, an, seg, mon_x.an, mon_x.seg);
                    end
                end
            end
            fd_exp = (rst_run == 0 && cyc != 0 && cyc % 16 == 0);
            n_cmp++;
            if (frame_done !== fd_exp) begin
                n_err++;
                $display("FAIL frame_done cyc=%0d: got %b, expected %b", cyc, frame_done, fd_exp);
            end
        end
    end

    task automatic push(input logic [11:0] e, input int id);
        exp_t x;
        x.an  = e[11:8];
        x.seg = e[7:0];
        x.id  = id;
        exp_q.push_back(x);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 400 && cyc != target; i++) @(negedge clk);
        if (cyc != target) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_timeout: cyc=%0d, expected %0d", cyc, target);
        end
    endtask

    // Inputs go in just before the frame's first tick edge, so a load lands on a tick
    task automatic frame(input bit ld, input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input bit lz, input logic [3:0] bm,
                         input logic [11:0] e0, input logic [11:0] e1,
                         input logic [11:0] e2, input logic [11:0] e3);
        if (fr > 0) wait_cyc(16 * fr - 1);
        data       = d;
        dp_en      = dp;
        blank_en   = bl;
        lz_en      = lz;
        blink_mask = bm;
        load       = ld;
        push(e0, fr * 4);
        push(e1, fr * 4 + 1);
        push(e2, fr * 4 + 2);
        push(e3, fr * 4 + 3);
        @(negedge clk);
        load = 1'b0;
        fr++;
    endtask

    initial begin
        push(12'hFFF, 900);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        frame(0, 16'h0000, 4'h0, 4'h0, 0, 4'h0, 12'hE03, 12'hD03, 12'hB03, 12'h703);
        frame(1, 16'h1234, 4'h0, 4'h0, 0, 4'h0, 12'hE99, 12'hD0D, 12'hB25, 12'h79F);
        frame(1, 16'h0050, 4'h0, 4'h0, 1, 4'h0, 12'hE03, 12'hD49, 12'hFFF, 12'hFFF);
        frame(1, 16'h0000, 4'h0, 4'h0, 1, 4'h0, 12'hE03, 12'hFFF, 12'hFFF, 12'hFFF);
        frame(1, 16'h1234, 4'h4, 4'h0, 0, 4'h0, 12'hE99, 12'hD0D, 12'hB24, 12'h79F);
        frame(1, 16'h1234, 4'h0, 4'h1, 0, 4'h0, 12'hFFF, 12'hD0D, 12'hB25, 12'h79F);
        frame(0, 16'hABCD, 4'hF, 4'hF, 0, 4'h0, 12'hFFF, 12'hD0D, 12'hB25, 12'h79F);
        frame(1, 16'h1234, 4'h0, 4'h0, 0, 4'h8, 12'hE99, 12'hD0D, 12'hB25, 12'hFFF);
        frame(0, 16'h1234, 4'h0, 4'h0, 0, 4'h8, 12'hE99, 12'hD0D, 12'hB25, 12'h79F);
        frame(0, 16'h1234, 4'h0, 4'h0, 0, 4'h8, 12'hE99, 12'hD0D, 12'hB25, 12'h79F);
        frame(0, 16'h1234, 4'h0, 4'h0, 0, 4'h8, 12'hE99, 12'hD0D, 12'hB25, 12'hFFF);
        frame(0, 16'h1234, 4'h0, 4'h0, 0, 4'h8, 12'hE99, 12'hD0D, 12'hB25, 12'hFFF);
        frame(0, 16'h1234, 4'h0, 4'h0, 0, 4'h8, 12'hE99, 12'hD0D, 12'hB25, 12'h79F);
        frame(1, 16'h0050, 4'h0, 4'h0, 0, 4'h0, 12'hE03, 12'hD49, 12'hB03, 12'h703);

        // Reset one cycle into the digit-2 slot, with a competing load
        push(12'hE03, 956);
        push(12'hD49, 957);
        wait_cyc(233);
        rst        = 1'b1;
        load       = 1'b1;
        data       = 16'h1234;
        lz_en      = 1'b1;
        blink_mask = 4'h0;
        push(12'hFFF, 901);
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        fr   = 0;
        frame(0, 16'h1234, 4'h0, 4'h0, 1, 4'h0, 12'hE03, 12'hFFF, 12'hFFF, 12'hFFF);
        frame(0, 16'h1234, 4'h0, 4'h0, 0, 4'h0, 12'hE03, 12'hD03, 12'hB03, 12'h703);
        wait_cyc(31);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expect: %0d samples left, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
